// File: rtl/sram_soc_responder_if.sv
// CPU-side SRAM-like instruction and data ports, shared between the core (master) and the responder (slave).
// Read data comes back one cycle after the request. There is no ready signal because the responder accepts every request.
interface sram_soc_responder_if;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (
      output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      input  inst_sram_rdata, data_sram_rdata
   );

   modport slave (
      input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      output inst_sram_rdata, data_sram_rdata
   );
endinterface

// File: rtl/sram_soc_responder.sv
// Shared word RAM plus LED/NUM/TIMER/SWITCH registers that serve the core's instruction and data ports.
// Read data is registered (1-cycle latency). The block is always ready and never stalls.
module sram_soc_responder #(
   parameter int unsigned RAM_AW    = 12,
   parameter logic [31:0] RAM_BASE  = 32'h1FC0_0000,
   parameter logic [15:0] CONF_BASE = 16'h1FAF
) (
   input  logic              clk,
   input  logic              resetn,
   sram_soc_responder_if.slave bus,
   input  logic [7:0]        switch_in,
   output logic [15:0]       led_out,
   output logic [31:0]       num_out,
   output logic [7:0]        err_cnt
);
   localparam int unsigned RAM_WORDS = 1 << RAM_AW;

   logic [31:0] ram_q [RAM_WORDS];

   logic [31:0] inst_rdata_q, inst_rdata_d;
   logic [31:0] data_rdata_q, data_rdata_d;
   logic [15:0] led_q, led_d;
   logic [31:0] num_q, num_d;
   logic [31:0] timer_q, timer_d;
   logic [7:0]  err_q, err_d;

   logic [RAM_AW-1:0] inst_idx, data_idx;
   logic              inst_ram_hit, data_ram_hit, conf_hit;
   logic [15:0]       data_off;
   logic              sel_led, sel_num, sel_timer, sel_switch, periph_hit;
   logic              data_wr;

   assign inst_idx     = bus.inst_sram_addr[RAM_AW+1:2];
   assign data_idx     = bus.data_sram_addr[RAM_AW+1:2];
   assign inst_ram_hit = bus.inst_sram_addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2];
   assign data_ram_hit = bus.data_sram_addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2];
   assign conf_hit     = bus.data_sram_addr[31:16] == CONF_BASE;
   assign data_off     = {bus.data_sram_addr[15:2], 2'b00};
   assign sel_led      = conf_hit && (data_off == 16'hF000);
   assign sel_num      = conf_hit && (data_off == 16'hF010);
   assign sel_timer    = conf_hit && (data_off == 16'hE000);
   assign sel_switch   = conf_hit && (data_off == 16'hF020);
   assign periph_hit   = sel_led || sel_num || sel_timer || sel_switch;
   assign data_wr      = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);

   // The inst port never writes, and the low address bits do not take part in word indexing.
   logic unused_ok;
   assign unused_ok = ^{bus.inst_sram_wen, bus.inst_sram_wdata,
                        bus.inst_sram_addr[1:0], bus.data_sram_addr[1:0]};

   always_comb begin
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      led_d        = led_q;
      num_d        = num_q;
      timer_d      = timer_q + 32'd1;
      err_d        = err_q;

      if (bus.inst_sram_en) begin
         inst_rdata_d = inst_ram_hit ? ram_q[inst_idx] : 32'h0000_0000;
      end

      if (bus.data_sram_en) begin
         if (data_ram_hit)    data_rdata_d = ram_q[data_idx];
         else if (sel_led)    data_rdata_d = {16'h0000, led_q};
         else if (sel_num)    data_rdata_d = num_q;
         else if (sel_timer)  data_rdata_d = timer_q;
         else if (sel_switch) data_rdata_d = {24'h00_0000, switch_in};
         else                 data_rdata_d = 32'h0000_0000;

         if (!data_ram_hit && !periph_hit && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
         end
      end

      // A software write to TIMER takes priority over that cycle's increment.
      if (data_wr && !data_ram_hit) begin
         if (sel_led)   led_d   = bus.data_sram_wdata[15:0];
         if (sel_num)   num_d   = bus.data_sram_wdata;
         if (sel_timer) timer_d = bus.data_sram_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         inst_rdata_q <= 32'h0000_0000;
         data_rdata_q <= 32'h0000_0000;
         led_q        <= 16'h0000;
         num_q        <= 32'h0000_0000;
         timer_q      <= 32'h0000_0000;
         err_q        <= 8'h00;
      end else begin
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
         led_q        <= led_d;
         num_q        <= num_d;
         timer_q      <= timer_d;
         err_q        <= err_d;
      end
   end

   // Nonblocking RAM update means a same-cycle read on either port still sees the old word.
   always_ff @(posedge clk) begin
      if (resetn && bus.data_sram_en && data_ram_hit) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.data_sram_wen[i]) begin
               ram_q[data_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

   assign bus.inst_sram_rdata = inst_rdata_q;
   assign bus.data_sram_rdata = data_rdata_q;
   assign led_out             = led_q;
   assign num_out             = num_q;
   assign err_cnt             = err_q;
endmodule

// File: tb/tb_sram_soc_responder.sv
// Directed bench for sram_soc_responder: reset, RAM byte writes, read-during-write, timer wrap,
// peripheral registers and err_cnt saturation, each checked against hand-computed values.
module tb_sram_soc_responder;
   logic        clk;
   logic        resetn;
   logic [7:0]  switch_in;
   logic [15:0] led_out;
   logic [31:0] num_out;
   logic [7:0]  err_cnt;
   int          n_cmp;
   int          n_err;

   sram_soc_responder_if bus_if ();

   sram_soc_responder dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus_if),
      .switch_in (switch_in),
      .led_out   (led_out),
      .num_out   (num_out),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_if.inst_sram_en    = 1'b0;
      bus_if.inst_sram_wen   = 4'hF;
      bus_if.inst_sram_addr  = 32'h0;
      bus_if.inst_sram_wdata = 32'hFFFF_FFFF;
      bus_if.data_sram_en    = 1'b0;
      bus_if.data_sram_wen   = 4'h0;
      bus_if.data_sram_addr  = 32'h0;
      bus_if.data_sram_wdata = 32'h0;
   endtask

   task automatic dreq(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      bus_if.data_sram_en    = 1'b1;
      bus_if.data_sram_addr  = a;
      bus_if.data_sram_wen   = w;
      bus_if.data_sram_wdata = d;
      tick();
      bus_if.data_sram_en    = 1'b0;
      bus_if.data_sram_wen   = 4'h0;
   endtask

   task automatic ireq(input logic [31:0] a);
      bus_if.inst_sram_en   = 1'b1;
      bus_if.inst_sram_addr = a;
      tick();
      bus_if.inst_sram_en   = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not complete");
   end

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      switch_in = 8'h00;
      resetn    = 1'b0;
      idle();
      tick();
      tick();
      resetn = 1'b1;

      // Make state non-zero so the reset check below actually tests something.
      dreq(32'h1FAF_F000, 4'hF, 32'h0000_1234);
      dreq(32'h1FAF_F010, 4'hF, 32'hCAFE_F00D);
      dreq(32'h0000_0000, 4'h0, 32'h0);
      check("pre_led", {16'h0, led_out}, 32'h0000_1234);
      check("pre_err", {24'h0, err_cnt}, 32'h0000_0001);
      repeat (5) tick();

      // Reset for 2 cycles while requests are pending.
      resetn                = 1'b0;
      bus_if.data_sram_en   = 1'b1;
      bus_if.data_sram_addr = 32'h1FAF_F010;
      bus_if.inst_sram_en   = 1'b1;
      bus_if.inst_sram_addr = 32'h1FC0_0000;
      tick();
      tick();
      idle();
      check("rst_drdata", bus_if.data_sram_rdata, 32'h0);
      check("rst_irdata", bus_if.inst_sram_rdata, 32'h0);
      check("rst_led", {16'h0, led_out}, 32'h0);
      check("rst_num", num_out, 32'h0);
      check("rst_err", {24'h0, err_cnt}, 32'h0);
      resetn = 1'b1;
      dreq(32'h1FAF_E000, 4'h0, 32'h0);
      check("rst_timer", bus_if.data_sram_rdata, 32'h0);
      dreq(32'h1FAF_E000, 4'h0, 32'h0);
      check("timer_run", bus_if.data_sram_rdata, 32'h1);

      // Word write, then a byte-lane write, then read back on both ports.
      dreq(32'h1FC0_0010, 4'hF, 32'hDEAD_BEEF);
      dreq(32'h1FC0_0010, 4'b0100, 32'h5555_5555);
      dreq(32'h1FC0_0010, 4'h0, 32'h0);
      check("lw_byte", bus_if.data_sram_rdata, 32'hDE55_BEEF);
      tick();
      check("lw_hold", bus_if.data_sram_rdata, 32'hDE55_BEEF);
      ireq(32'h1FC0_0010);
      check("inst_rd", bus_if.inst_sram_rdata, 32'hDE55_BEEF);

      // An inst read in the same cycle as a data write to that word returns the old value.
      dreq(32'h1FC0_0020, 4'hF, 32'h0);
      bus_if.inst_sram_en    = 1'b1;
      bus_if.inst_sram_addr  = 32'h1FC0_0020;
      bus_if.data_sram_en    = 1'b1;
      bus_if.data_sram_addr  = 32'h1FC0_0020;
      bus_if.data_sram_wen   = 4'hF;
      bus_if.data_sram_wdata = 32'h1234_5678;
      tick();
      idle();
      check("rdw_old", bus_if.inst_sram_rdata, 32'h0);
      ireq(32'h1FC0_0020);
      check("rdw_new", bus_if.inst_sram_rdata, 32'h1234_5678);

      // Load TIMER, then watch it wrap.
      dreq(32'h1FAF_E000, 4'hF, 32'hFFFF_FFFE);
      dreq(32'h1FAF_E000, 4'h0, 32'h0);
      check("timer_1", bus_if.data_sram_rdata, 32'hFFFF_FFFE);
      dreq(32'h1FAF_E000, 4'h0, 32'h0);
      check("timer_2", bus_if.data_sram_rdata, 32'hFFFF_FFFF);
      dreq(32'h1FAF_E000, 4'h0, 32'h0);
      check("timer_wrap", bus_if.data_sram_rdata, 32'h0);

      // Peripheral registers.
      dreq(32'h1FAF_F000, 4'hF, 32'h0001_ABCD);
      check("led_out", {16'h0, led_out}, 32'h0000_ABCD);
      dreq(32'h1FAF_F000, 4'h0, 32'h0);
      check("led_rd", bus_if.data_sram_rdata, 32'h0000_ABCD);
      dreq(32'h1FAF_F010, 4'hF, 32'h89AB_CDEF);
      check("num_out", num_out, 32'h89AB_CDEF);
      dreq(32'h1FAF_F010, 4'h0, 32'h0);
      check("num_rd", bus_if.data_sram_rdata, 32'h89AB_CDEF);
      switch_in = 8'hA5;
      dreq(32'h1FAF_F020, 4'h0, 32'h0);
      check("sw_rd", bus_if.data_sram_rdata, 32'h0000_00A5);
      dreq(32'h1FAF_F020, 4'hF, 32'h0000_0000);
      dreq(32'h1FAF_F020, 4'h0, 32'h0);
      check("sw_ro", bus_if.data_sram_rdata, 32'h0000_00A5);
      check("err_mapped", {24'h0, err_cnt}, 32'h0);

      // Unmapped accesses: in-page hole, inst miss (not counted), write to nowhere, then saturation.
      dreq(32'h1FAF_F030, 4'h0, 32'h0);
      check("hole_rd", bus_if.data_sram_rdata, 32'h0);
      check("hole_err", {24'h0, err_cnt}, 32'h1);
      ireq(32'h0000_0000);
      check("inst_miss", bus_if.inst_sram_rdata, 32'h0);
      check("inst_noerr", {24'h0, err_cnt}, 32'h1);
      dreq(32'h0000_0000, 4'hF, 32'hFFFF_FFFF);
      check("unm_wr_err", {24'h0, err_cnt}, 32'h2);
      for (int i = 0; i < 300; i++) begin
         dreq(32'h0000_0000, 4'h0, 32'h0);
         check("unm_rd", bus_if.data_sram_rdata, 32'h0);
         if (i == 9) check("err_mid", {24'h0, err_cnt}, 32'd12);
      end
      check("err_sat", {24'h0, err_cnt}, 32'h0000_00FF);
      check("led_keep", {16'h0, led_out}, 32'h0000_ABCD);
      check("num_keep", num_out, 32'h89AB_CDEF);
      dreq(32'h1FC0_0010, 4'h0, 32'h0);
      check("ram_keep", bus_if.data_sram_rdata, 32'hDE55_BEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
